// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - native memory bus bundle between two masters, the arbiter and one slave
// master: the SoC side (both requesters plus the slave); slave: the arbiter itself.
interface mem_bus_arbiter_if #(
  parameter int unsigned CNT_W = 8
);
  logic             m0_valid;
  logic [31:0]      m0_addr;
  logic [31:0]      m0_wdata;
  logic [3:0]       m0_wen;
  logic             m0_ready;
  logic [31:0]      m0_rdata;

  logic             m1_valid;
  logic [31:0]      m1_addr;
  logic [31:0]      m1_wdata;
  logic [3:0]       m1_wen;
  logic             m1_ready;
  logic [31:0]      m1_rdata;

  logic             s_valid;
  logic [31:0]      s_addr;
  logic [31:0]      s_wdata;
  logic [3:0]       s_wen;
  logic             s_ready;
  logic [31:0]      s_rdata;

  logic             bus_err;
  logic [CNT_W-1:0] err_count;

  modport master (
    output m0_valid, m0_addr, m0_wdata, m0_wen,
    input  m0_ready, m0_rdata,
    output m1_valid, m1_addr, m1_wdata, m1_wen,
    input  m1_ready, m1_rdata,
    input  s_valid, s_addr, s_wdata, s_wen,
    output s_ready, s_rdata,
    input  bus_err, err_count
  );

  modport slave (
    input  m0_valid, m0_addr, m0_wdata, m0_wen,
    output m0_ready, m0_rdata,
    input  m1_valid, m1_addr, m1_wdata, m1_wen,
    output m1_ready, m1_rdata,
    output s_valid, s_addr, s_wdata, s_wen,
    input  s_ready, s_rdata,
    output bus_err, err_count
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-master round-robin arbiter with bus-timeout watchdog
// Grant is held for one transaction; a dead DONE cycle separates transactions.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT   = 256,
  parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             resetn,
  mem_bus_arbiter_if.slave bus
);
  localparam int unsigned    TW       = $clog2(TIMEOUT);
  localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_owner_q, last_owner_d;
  logic [TW-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;

  logic             own_valid;
  logic             busy;
  logic             s_valid_c;
  logic             done_c;
  logic             err_c;
  logic [31:0]      rdata_c;

  assign busy      = (state_q == BUSY);
  assign own_valid = owner_q ? bus.m1_valid : bus.m0_valid;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      tmo_cnt_q    <= '0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      tmo_cnt_q    <= tmo_cnt_d;
      err_count_q  <= err_count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    tmo_cnt_d    = tmo_cnt_q;
    err_count_d  = err_count_q;
    s_valid_c    = 1'b0;
    done_c       = 1'b0;
    err_c        = 1'b0;
    rdata_c      = '0;

    case (state_q)
      IDLE: begin
        if (bus.m0_valid || bus.m1_valid) begin
          // On a tie the master that did not finish last gets the bus.
          owner_d   = (bus.m0_valid && bus.m1_valid) ? ~last_owner_q : bus.m1_valid;
          tmo_cnt_d = '0;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        if (!own_valid) begin
          // Owner withdrew without a response: close quietly, fairness untouched.
          state_d = DONE;
        end else if (bus.s_ready) begin
          s_valid_c    = 1'b1;
          done_c       = 1'b1;
          rdata_c      = bus.s_rdata;
          last_owner_d = owner_q;
          state_d      = DONE;
        end else if (tmo_cnt_q == TMO_LAST) begin
          done_c       = 1'b1;
          err_c        = 1'b1;
          rdata_c      = ERR_RDATA;
          last_owner_d = owner_q;
          state_d      = DONE;
          if (err_count_q != '1) begin
            err_count_d = err_count_q + 1'b1;
          end
        end else begin
          s_valid_c = 1'b1;
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.s_valid   = s_valid_c;
  assign bus.s_addr    = busy ? (owner_q ? bus.m1_addr  : bus.m0_addr)  : '0;
  assign bus.s_wdata   = busy ? (owner_q ? bus.m1_wdata : bus.m0_wdata) : '0;
  assign bus.s_wen     = busy ? (owner_q ? bus.m1_wen   : bus.m0_wen)   : '0;

  assign bus.m0_ready  = done_c && !owner_q;
  assign bus.m1_ready  = done_c && owner_q;
  assign bus.m0_rdata  = (done_c && !owner_q) ? rdata_c : '0;
  assign bus.m1_rdata  = (done_c && owner_q)  ? rdata_c : '0;

  assign bus.bus_err   = err_c;
  assign bus.err_count = err_count_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - randomized self-checking bench for mem_bus_arbiter against a transaction-level model
module tb_mem_bus_arbiter;
  localparam int unsigned TMO  = 16;
  localparam int unsigned CW   = 2;
  localparam logic [31:0] ERRW = 32'hDEAD_BEEF;
  localparam int          SAT  = (1 << CW) - 1;

  logic clk    = 1'b0;
  logic resetn = 1'b0;

  mem_bus_arbiter_if #(.CNT_W(CW)) bus ();

  mem_bus_arbiter #(.TIMEOUT(TMO), .ERR_RDATA(ERRW), .CNT_W(CW)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // requester agents
  logic        pend      [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_wen   [2];
  int          auto_pct  = 0;
  logic        noise0    = 1'b0;

  // slave agent
  int          lat_fix   = 0;
  logic        fix_rd_en = 1'b0;
  logic [31:0] fix_rd    = 32'h0;
  logic        active    = 1'b0;
  int          cnt       = 0;
  int          lat       = 0;
  int          sv_cnt    = 0;

  // reference model state
  logic        exp_owner    = 1'b0;
  logic        last_owner_m = 1'b1;
  int          err_m        = 0;
  logic        prev_v0      = 1'b0;
  logic        prev_v1      = 1'b0;
  int          cyc          = 0;
  int          last_done_cyc = -100;
  int          done_cnt     = 0;
  int          aborts       = 0;
  int          err_pulses   = 0;
  int          rdy_cnt [2];
  logic        grant_q [$];
  int          done_cyc_q [$];
  logic [31:0] last_rdata   = 32'h0;
  logic        last_err     = 1'b0;
  int          last_len     = 0;
  int          last_sv      = 0;

  function automatic logic [31:0] slv_data(input logic [31:0] a);
    return fix_rd_en ? fix_rd : (a ^ 32'h5A5A_0F0F);
  endfunction

  task automatic post(input logic k, input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
    pend[k]      = 1'b1;
    req_addr[k]  = a;
    req_wdata[k] = d;
    req_wen[k]   = w;
  endtask

  task automatic drive_masters();
    bus.m0_valid = pend[0];
    bus.m0_addr  = req_addr[0];
    bus.m0_wdata = req_wdata[0];
    bus.m0_wen   = req_wen[0];
    if (noise0 && active) begin
      bus.m0_valid = 1'($urandom);
      bus.m0_addr  = $urandom;
      bus.m0_wdata = $urandom;
      bus.m0_wen   = 4'($urandom);
    end
    bus.m1_valid = pend[1];
    bus.m1_addr  = req_addr[1];
    bus.m1_wdata = req_wdata[1];
    bus.m1_wen   = req_wen[1];
  endtask

  task automatic cycle();
    logic        exp_to;
    logic [31:0] exp_rd;
    logic [31:0] got_rd;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      if (!pend[k] && auto_pct > 0 && int'($urandom_range(0, 99)) < auto_pct)
        post(k[0], {k[0], 31'($urandom)}, $urandom, 4'($urandom));
    end
    bus.s_ready = 1'b0;
    bus.s_rdata = 32'h0;
    drive_masters();
    #1;
    if (active) begin
      cnt++;
      bus.s_ready = (cnt == lat);
      bus.s_rdata = (cnt == lat) ? slv_data(bus.s_addr) : 32'h0;
    end else if (bus.s_valid) begin
      exp_owner = (prev_v0 && prev_v1) ? ~last_owner_m : prev_v1;
      chk("grant_had_request", prev_v0 | prev_v1, 1);
      chk("min_spacing", (cyc - last_done_cyc) >= 3, 1);
      grant_q.push_back(exp_owner);
      active = 1'b1;
      cnt    = 1;
      sv_cnt = 0;
      if (lat_fix != 0) lat = lat_fix;
      else if ($urandom_range(0, 7) == 0) lat = int'($urandom_range(14, 20));
      else lat = int'($urandom_range(1, 6));
      bus.s_ready = (lat == 1);
      bus.s_rdata = (lat == 1) ? slv_data(bus.s_addr) : 32'h0;
    end

    @(negedge clk);
    if (!active) chk("slave_idle", {bus.s_valid, bus.s_addr, bus.s_wen}, 0);
    if (active && bus.s_valid) begin
      sv_cnt++;
      chk("s_addr",  bus.s_addr,  req_addr[exp_owner]);
      chk("s_wdata", bus.s_wdata, req_wdata[exp_owner]);
      chk("s_wen",   bus.s_wen,   req_wen[exp_owner]);
    end
    rdy_cnt[0] += int'(bus.m0_ready);
    rdy_cnt[1] += int'(bus.m1_ready);
    err_pulses += int'(bus.bus_err);
    if (bus.m0_ready || bus.m1_ready || bus.bus_err) begin
      if (!active) begin
        chk("spurious_ready", {bus.m1_ready, bus.m0_ready, bus.bus_err}, 0);
      end else begin
        exp_to = (lat > int'(TMO));
        exp_rd = exp_to ? ERRW : slv_data(req_addr[exp_owner]);
        got_rd = exp_owner ? bus.m1_rdata : bus.m0_rdata;
        chk("ready_owner",  {bus.m1_ready, bus.m0_ready}, exp_owner ? 2'b10 : 2'b01);
        chk("done_cycle",   cnt, exp_to ? TMO : lat);
        chk("rdata",        got_rd, exp_rd);
        chk("other_rdata",  exp_owner ? bus.m0_rdata : bus.m1_rdata, 0);
        chk("bus_err",      bus.bus_err, exp_to);
        chk("s_valid_done", bus.s_valid, !exp_to);
        chk("err_count",    bus.err_count, err_m);
        if (exp_to && err_m < SAT) err_m++;
        last_owner_m    = exp_owner;
        pend[exp_owner] = 1'b0;
        active          = 1'b0;
        last_rdata      = got_rd;
        last_err        = bus.bus_err;
        last_len        = cnt;
        last_sv         = sv_cnt;
        done_cnt++;
        done_cyc_q.push_back(cyc);
        last_done_cyc   = cyc;
      end
    end else if (active && !bus.s_valid) begin
      aborts++;
      active        = 1'b0;
      last_done_cyc = cyc;
    end
    if (active && cnt >= int'(TMO)) begin
      chk("watchdog_fired", cnt, TMO - 1);
      active          = 1'b0;
      pend[exp_owner] = 1'b0;
    end
    prev_v0 = bus.m0_valid;
    prev_v1 = bus.m1_valid;
    cyc++;
  endtask

  task automatic wait_done(input string tag, input int n, input int budget);
    int target;
    int i;
    target = done_cnt + n;
    i = 0;
    while (done_cnt < target && i < budget) begin
      cycle();
      i++;
    end
    chk({tag, "_done"}, done_cnt >= target, 1);
  endtask

  task automatic drain(input int budget);
    int i;
    i = 0;
    while ((pend[0] || pend[1] || active) && i < budget) begin
      cycle();
      i++;
    end
    chk("drain", pend[0] || pend[1] || active, 0);
  endtask

  task automatic do_reset();
    resetn      = 1'b0;
    pend[0]     = 1'b0;
    pend[1]     = 1'b0;
    active      = 1'b0;
    noise0      = 1'b0;
    auto_pct    = 0;
    drive_masters();
    bus.s_ready = 1'b0;
    bus.s_rdata = 32'h0;
    last_owner_m  = 1'b1;
    err_m         = 0;
    prev_v0       = 1'b0;
    prev_v1       = 1'b0;
    last_done_cyc = cyc - 100;
    grant_q.delete();
    done_cyc_q.delete();
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk("rst_release_ctl", {bus.s_valid, bus.m0_ready, bus.m1_ready, bus.bus_err, bus.err_count}, 0);
    chk("rst_release_bus", {bus.s_addr, bus.m0_rdata}, 0);
  endtask

  initial begin
    int ab0;
    int d0;
    for (int k = 0; k < 2; k++) begin
      req_addr[k]  = 32'h0;
      req_wdata[k] = 32'h0;
      req_wen[k]   = 4'h0;
      rdy_cnt[k]   = 0;
    end
    do_reset();

    // single read, four-cycle slave
    fix_rd_en = 1'b1;
    fix_rd    = 32'h1234_5678;
    lat_fix   = 4;
    post(1'b0, 32'h0010_0000, 32'h0, 4'h0);
    wait_done("t1", 1, 30);
    repeat (3) cycle();
    chk("t1_rdata",      last_rdata, 32'h1234_5678);
    chk("t1_svalid_len", last_sv, 4);
    chk("t1_m0_pulses",  rdy_cnt[0], 1);
    chk("t1_m1_pulses",  rdy_cnt[1], 0);
    fix_rd_en = 1'b0;

    // both masters hammering, one-cycle slave
    do_reset();
    lat_fix  = 1;
    auto_pct = 100;
    wait_done("t2", 20, 100);
    auto_pct = 0;
    for (int i = 0; i < 20 && i < grant_q.size(); i++) chk("t2_grant", grant_q[i], i[0]);
    for (int i = 1; i < done_cyc_q.size(); i++) chk("t2_spacing", done_cyc_q[i] - done_cyc_q[i-1], 3);
    drain(50);

    // m1 write while m0 wiggles its inputs
    rdy_cnt[0] = 0;
    rdy_cnt[1] = 0;
    lat_fix = 5;
    noise0  = 1'b1;
    post(1'b1, 32'h2040_0004, 32'hCAFE_F00D, 4'hF);
    wait_done("t3", 1, 30);
    noise0 = 1'b0;
    chk("t3_m1_pulses", rdy_cnt[1], 1);
    chk("t3_m0_pulses", rdy_cnt[0], 0);

    // watchdog, then a response landing on the final watchdog cycle
    do_reset();
    err_pulses = 0;
    lat_fix = 100;
    post(1'b0, 32'h0000_1000, 32'h0, 4'h0);
    wait_done("t4a", 1, 40);
    cycle();
    chk("t4_rdata",     last_rdata, ERRW);
    chk("t4_len",       last_len, 16);
    chk("t4_err_pulse", err_pulses, 1);
    chk("t4_err_count", bus.err_count, 1);
    lat_fix = 16;
    post(1'b1, 32'h8000_2000, 32'h0, 4'h0);
    wait_done("t4b", 1, 40);
    cycle();
    chk("t4b_rdata",     last_rdata, 32'h8000_2000 ^ 32'h5A5A_0F0F);
    chk("t4b_err",       last_err, 0);
    chk("t4b_err_count", bus.err_count, 1);

    // saturation, then owner abandoning its request
    lat_fix = 100;
    for (int i = 0; i < 4; i++) begin
      post(i[0], {i[0], 31'h100 + 31'(i)}, 32'h0, 4'h0);
      wait_done("t5_tmo", 1, 40);
    end
    cycle();
    chk("t5_saturated", bus.err_count, 3);
    ab0 = aborts;
    d0  = rdy_cnt[0] + rdy_cnt[1];
    post(1'b0, 32'h0000_3000, 32'h0, 4'h0);
    repeat (3) cycle();
    pend[0] = 1'b0;
    repeat (4) cycle();
    chk("t5_abort_seen",   aborts - ab0, 1);
    chk("t5_no_ready",     rdy_cnt[0] + rdy_cnt[1] - d0, 0);
    chk("t5_count_steady", bus.err_count, 3);
    lat_fix = 2;
    post(1'b1, 32'h8000_3000, 32'h1, 4'h3);
    wait_done("t5_after", 1, 20);

    // reset during a transaction
    lat_fix = 100;
    post(1'b0, 32'h0000_4000, 32'h0, 4'h0);
    repeat (4) cycle();
    #1 resetn = 1'b0;
    #1;
    chk("t6_zero_ctl",  {bus.s_valid, bus.m0_ready, bus.m1_ready, bus.bus_err, bus.err_count}, 0);
    chk("t6_zero_addr", bus.s_addr, 0);
    do_reset();
    lat_fix = 1;
    post(1'b0, 32'h0000_5000, 32'h0, 4'h0);
    post(1'b1, 32'h8000_5000, 32'h0, 4'h0);
    wait_done("t6", 1, 20);
    chk("t6_first_grant", grant_q.size() > 0 ? grant_q[0] : 1'b1, 0);
    drain(50);

    // randomized traffic
    do_reset();
    lat_fix  = 0;
    ab0      = aborts;
    d0       = done_cnt;
    auto_pct = 40;
    repeat (3000) cycle();
    auto_pct = 0;
    drain(200);
    chk("rand_volume", (done_cnt - d0) >= 100, 1);
    chk("rand_aborts", aborts - ab0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
